br_write_buffer: RTL and testbench

Write-side companion to the BR register bank. It accepts register write-back requests from the pipeline through a valid/ready handshake and queues them in a small FIFO. It drains one entry per cycle onto the BR write port (Dir, Di, Regw). It also forwards pending, not-yet-committed data to the two BR read addresses, so readers see the youngest value before BR is updated.

---
 rtl/br_pkg.sv | 15 +
 rtl/br_fwd_match.sv | 28 ++
 rtl/br_write_buffer.sv | 136 +++++++++++++
 tb/tb_br_write_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types and constants for the BR register-bank write path.
package br_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  // Register $0 is hardwired; writes to it are swallowed.
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] dir;
    logic [REG_DW-1:0] data;
  } br_wr_entry_t;

endpackage

// File: rtl/br_fwd_match.sv
// Address compare and youngest-first select for one BR read port.
// Candidate 0 is the youngest; higher indices are progressively older.
module br_fwd_match #(
  parameter int N  = 5,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic [AW-1:0]         ra_i,
  input  logic [N-1:0]          cand_vld_i,
  input  logic [N-1:0][AW-1:0]  cand_dir_i,
  input  logic [N-1:0][DW-1:0]  cand_data_i,
  output logic                  hit_o,
  output logic [DW-1:0]         data_o
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_vld_i[i] && (cand_dir_i[i] == ra_i) && (ra_i != '0)) begin
        hit_o  = 1'b1;
        data_o = cand_data_i[i];
      end
    end
  end

endmodule

// File: rtl/br_write_buffer.sv
// Write-back FIFO in front of the BR register bank with read forwarding.
module br_write_buffer
  import br_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       WrEn,
  input  logic [AW-1:0]              WrDir,
  input  logic [DW-1:0]              WrData,
  output logic                       WrReady,
  input  logic                       Drain,
  output logic [AW-1:0]              Dir,
  output logic [DW-1:0]              Di,
  output logic                       Regw,
  input  logic [AW-1:0]              RA1,
  input  logic [AW-1:0]              RA2,
  output logic [DW-1:0]              Fwd1,
  output logic                       Fwd1Hit,
  output logic [DW-1:0]              Fwd2,
  output logic                       Fwd2Hit,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NC = DEPTH + 1;

  logic [AW-1:0]    dir_mem_q  [DEPTH];
  logic [DW-1:0]    data_mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             regw_q, regw_d;
  logic [AW-1:0]    dir_q, dir_d;
  logic [DW-1:0]    di_q, di_d;

  logic push, pop;

  logic [NC-1:0]         cand_vld;
  logic [NC-1:0][AW-1:0] cand_dir;
  logic [NC-1:0][DW-1:0] cand_data;

  // Full blocks the handshake outright, even if a pop frees a slot this cycle.
  assign WrReady = (count_q < CW'(DEPTH));
  assign Empty   = (count_q == '0);
  assign Count   = count_q;
  assign Regw    = regw_q;
  assign Dir     = dir_q;
  assign Di      = di_q;

  // $0 writes complete the handshake but are dropped.
  assign push = WrEn && WrReady && (WrDir != AW'(REG_ZERO));
  assign pop  = Drain && !Empty;

  // Pointer, occupancy and output-stage next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    valid_d  = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
    regw_d   = pop;
    dir_d    = pop ? dir_mem_q[rd_ptr_q]  : dir_q;
    di_d     = pop ? data_mem_q[rd_ptr_q] : di_q;
  end

  // Control state; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      regw_q   <= 1'b0;
      dir_q    <= '0;
      di_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      regw_q   <= regw_d;
      dir_q    <= dir_d;
      di_q     <= di_d;
    end
  end

  // Entry storage; contents are only meaningful under valid_q.
  always_ff @(posedge clk) begin
    if (push) begin
      dir_mem_q[wr_ptr_q]  <= WrDir;
      data_mem_q[wr_ptr_q] <= WrData;
    end
  end

  // Present queue entries youngest-first, then the committing output stage.
  always_comb begin
    logic [PW-1:0] slot;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot         = wr_ptr_q - PW'(k + 1);
      cand_vld[k]  = valid_q[slot];
      cand_dir[k]  = dir_mem_q[slot];
      cand_data[k] = data_mem_q[slot];
    end
    cand_vld[DEPTH]  = regw_q;
    cand_dir[DEPTH]  = dir_q;
    cand_data[DEPTH] = di_q;
  end

  br_fwd_match #(.N(NC), .AW(AW), .DW(DW)) u_fwd1 (
    .ra_i        (RA1),
    .cand_vld_i  (cand_vld),
    .cand_dir_i  (cand_dir),
    .cand_data_i (cand_data),
    .hit_o       (Fwd1Hit),
    .data_o      (Fwd1)
  );

  br_fwd_match #(.N(NC), .AW(AW), .DW(DW)) u_fwd2 (
    .ra_i        (RA2),
    .cand_vld_i  (cand_vld),
    .cand_dir_i  (cand_dir),
    .cand_data_i (cand_data),
    .hit_o       (Fwd2Hit),
    .data_o      (Fwd2)
  );

endmodule

// File: tb/tb_br_write_buffer.sv
// Bench for br_write_buffer: directed scenarios plus random traffic,
// checked against a queue-based reference model and a commit scoreboard.
module tb_br_write_buffer;
  import br_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        WrEn = 1'b0;
  logic [4:0]  WrDir = '0;
  logic [31:0] WrData = '0;
  logic        WrReady;
  logic        Drain = 1'b0;
  logic [4:0]  Dir;
  logic [31:0] Di;
  logic        Regw;
  logic [4:0]  RA1 = '0;
  logic [4:0]  RA2 = '0;
  logic [31:0] Fwd1, Fwd2;
  logic        Fwd1Hit, Fwd2Hit;
  logic [2:0]  Count;
  logic        Empty;

  int vectors = 0;
  int errors  = 0;
  int n_commit = 0;

  br_wr_entry_t pend[$];
  br_wr_entry_t commit_q[$];
  br_wr_entry_t m_last;
  logic         m_regw;

  br_write_buffer #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .WrEn(WrEn), .WrDir(WrDir), .WrData(WrData), .WrReady(WrReady),
    .Drain(Drain), .Dir(Dir), .Di(Di), .Regw(Regw),
    .RA1(RA1), .RA2(RA2),
    .Fwd1(Fwd1), .Fwd1Hit(Fwd1Hit), .Fwd2(Fwd2), .Fwd2Hit(Fwd2Hit),
    .Count(Count), .Empty(Empty)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Youngest pending write wins; the committing entry is the last resort.
  function automatic void fwd_model(input logic [4:0] ra, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (ra != 5'd0) begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (!hit && pend[i].dir == ra) begin
          hit  = 1'b1;
          data = pend[i].data;
        end
      end
      if (!hit && m_regw && m_last.dir == ra) begin
        hit  = 1'b1;
        data = m_last.data;
      end
    end
  endfunction

  // Reference model: a plain queue with capacity DEPTH.
  always @(posedge clk or negedge rst_n) begin
    br_wr_entry_t e;
    bit ready;
    if (!rst_n) begin
      pend.delete();
      commit_q.delete();
      m_last = '0;
      m_regw = 1'b0;
    end else begin
      ready = (pend.size() < DEPTH);
      if (Drain && pend.size() > 0) begin
        e = pend.pop_front();
        m_last = e;
        m_regw = 1'b1;
        commit_q.push_back(e);
      end else begin
        m_regw = 1'b0;
      end
      if (WrEn && ready && WrDir != 5'd0) begin
        e.dir  = WrDir;
        e.data = WrData;
        pend.push_back(e);
      end
    end
  end

  // Monitor: compare every observable against the model mid-cycle.
  always @(negedge clk) begin
    br_wr_entry_t e;
    logic h1, h2;
    logic [31:0] d1, d2;
    if (rst_n) begin
      cmp("Count", Count, pend.size());
      cmp("Empty", Empty, pend.size() == 0);
      cmp("WrReady", WrReady, pend.size() < DEPTH);
      cmp("Regw", Regw, m_regw);
      cmp("Dir_hold", Dir, m_last.dir);
      cmp("Di_hold", Di, m_last.data);
      fwd_model(RA1, h1, d1);
      fwd_model(RA2, h2, d2);
      cmp("Fwd1Hit", Fwd1Hit, h1);
      cmp("Fwd1", Fwd1, d1);
      cmp("Fwd2Hit", Fwd2Hit, h2);
      cmp("Fwd2", Fwd2, d2);
      if (Regw) begin
        if (commit_q.size() == 0) begin
          cmp("commit_unexpected", 1, 0);
        end else begin
          e = commit_q.pop_front();
          cmp("commit_Dir", Dir, e.dir);
          cmp("commit_Di", Di, e.data);
          n_commit++;
        end
      end
    end
  end

  task automatic drive(input logic wen, input logic [4:0] d, input logic [31:0] dat,
                       input logic dr, input logic [4:0] r1, input logic [4:0] r2);
    WrEn = wen; WrDir = d; WrData = dat; Drain = dr; RA1 = r1; RA2 = r2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  exp_d [4];
    logic [31:0] exp_v [4];
    int c0;

    #12 rst_n = 1'b1;
    cmp("rst_Count", Count, 0);
    cmp("rst_Empty", Empty, 1);
    cmp("rst_Regw", Regw, 0);
    cmp("rst_WrReady", WrReady, 1);

    // Single write
    drive(1, 1, 255, 1, 1, 0);
    cmp("t1_Count", Count, 1);
    cmp("t1_Regw_early", Regw, 0);
    cmp("t1_Fwd1Hit_q", Fwd1Hit, 1);
    cmp("t1_Fwd1_q", Fwd1, 255);
    drive(0, 0, 0, 1, 1, 0);
    cmp("t1_Regw", Regw, 1);
    cmp("t1_Dir", Dir, 1);
    cmp("t1_Di", Di, 255);
    cmp("t1_Fwd1Hit_out", Fwd1Hit, 1);
    cmp("t1_Fwd1_out", Fwd1, 255);
    drive(0, 0, 0, 1, 1, 0);
    cmp("t1_Regw_after", Regw, 0);
    cmp("t1_Fwd1Hit_after", Fwd1Hit, 0);

    // Fill and forward
    drive(1, 2, 356, 0, 0, 0);
    drive(1, 3, 646, 0, 0, 0);
    drive(1, 2, 149, 0, 0, 0);
    drive(1, 4, 506, 0, 0, 0);
    cmp("t2_WrReady_full", WrReady, 0);
    drive(1, 5, 105, 0, 2, 3);
    cmp("t2_Count", Count, 4);
    cmp("t2_Fwd1_young", Fwd1, 149);
    cmp("t2_Fwd2", Fwd2, 646);
    exp_d = '{5'd2, 5'd3, 5'd2, 5'd4};
    exp_v = '{32'd356, 32'd646, 32'd149, 32'd506};
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      cmp("t2_drain_Regw", Regw, 1);
      cmp("t2_drain_Dir", Dir, exp_d[i]);
      cmp("t2_drain_Di", Di, exp_v[i]);
    end
    drive(0, 0, 0, 1, 0, 0);
    cmp("t2_Empty", Empty, 1);
    cmp("t2_Regw_done", Regw, 0);

    // Register $0
    drive(1, 0, 105, 1, 0, 0);
    cmp("t3_Count", Count, 0);
    cmp("t3_Fwd1Hit", Fwd1Hit, 0);
    cmp("t3_Fwd1", Fwd1, 0);
    drive(0, 0, 0, 1, 0, 0);
    cmp("t3_Regw", Regw, 0);

    // Full plus pop on the same edge
    for (int i = 0; i < 4; i++) drive(1, 5'(6 + i), 32'(60 + 10 * i), 0, 0, 0);
    cmp("t4_Count_full", Count, 4);
    drive(1, 10, 100, 1, 0, 0);
    cmp("t4_Count_pop_only", Count, 3);
    cmp("t4_Dir_first", Dir, 6);
    drive(1, 10, 100, 1, 10, 0);
    cmp("t4_Count_push_pop", Count, 3);
    cmp("t4_Fwd1Hit", Fwd1Hit, 1);
    cmp("t4_Fwd1", Fwd1, 100);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0);
    cmp("t4_Empty", Empty, 1);

    // Pointer wrap
    c0 = n_commit;
    for (int i = 0; i < 10; i++) drive(1, 5'((i % 9) + 1), 32'(10 * i), 1, 5'((i % 9) + 1), 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0);
    cmp("t5_commits", n_commit - c0, 10);

    // Reset mid-operation
    for (int i = 0; i < 4; i++) drive(1, 5'(11 + i), 32'(1000 + i), 0, 0, 0);
    drive(0, 0, 0, 1, 11, 12);
    cmp("t6_Count", Count, 3);
    cmp("t6_Regw", Regw, 1);
    #2 rst_n = 1'b0;
    #1;
    cmp("t6_rst_Regw", Regw, 0);
    cmp("t6_rst_Dir", Dir, 0);
    cmp("t6_rst_Di", Di, 0);
    cmp("t6_rst_Count", Count, 0);
    cmp("t6_rst_Empty", Empty, 1);
    cmp("t6_rst_Fwd1Hit", Fwd1Hit, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 12, 13);
      cmp("t6_post_Regw", Regw, 0);
      cmp("t6_post_Fwd1Hit", Fwd1Hit, 0);
      cmp("t6_post_Fwd2Hit", Fwd2Hit, 0);
    end

    // Random traffic over a small address range to force forwarding collisions
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0, 0);
    cmp("final_Empty", Empty, 1);
    cmp("scoreboard_drained", commit_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
